gyro_tilt_integrator: RTL



---
 rtl/gyro_pkg.sv | 17 +
 rtl/gyro_avg_ring.sv | 51 +++++
 rtl/gyro_tilt_integrator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro tilt integrator.
// FSM state enum, turn constants in millidegrees, default deadband.
package gyro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } state_t;

  localparam int MDEG_HALF_TURN = 180000;
  localparam int MDEG_TURN      = 360000;

  localparam int DB_LO_DEF = -42;
  localparam int DB_HI_DEF = 10;

endpackage

// File: rtl/gyro_avg_ring.sv
// Single-channel moving-average ring buffer with exact running sum.
// Ports: CLK, RST_N, clr, push, wptr, sample in; avg out.
module gyro_avg_ring
  import gyro_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         clr,
  input  logic                         push,
  input  logic [AVG_LOG2-1:0]          wptr,
  input  logic signed [WIDTH-1:0]      sample,
  output logic signed [WIDTH+AVG_LOG2-1:0] avg
);

  localparam int SUMW  = WIDTH + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [SUMW-1:0]  sum_q;
  logic signed [SUMW-1:0]  sum_d;
  logic signed [WIDTH-1:0] old;

  assign old = mem[wptr];

  // avg reflects the sum including the sample being pushed,
  // so the caller can consume it on the same edge.
  always_comb begin
    sum_d = sum_q
          + {{AVG_LOG2{sample[WIDTH-1]}}, sample}
          - {{AVG_LOG2{old[WIDTH-1]}}, old};
  end

  assign avg = sum_d >>> AVG_LOG2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      sum_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= sample;
      sum_q     <= sum_d;
    end
  end

endmodule

// File: rtl/gyro_tilt_integrator.sv
// Multi-channel gyro rate-to-tilt integrator, one channel per clock.
// Ports: CLK, RST_N, RATE, ZERO in; ANGLE, VALID, BUSY out.
// Define GYRO_TILT_WRAP_EN to wrap angles mod 360000, else saturate.
module gyro_tilt_integrator
  import gyro_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 20,
  parameter int AVG_LOG2    = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DB_LO       = DB_LO_DEF,
  parameter int DB_HI       = DB_HI_DEF
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [CHANNELS*WIDTH-1:0]       RATE,
  input  logic                            ZERO,
  output logic [CHANNELS*ANGLE_WIDTH-1:0] ANGLE,
  output logic                            VALID,
  output logic                            BUSY
);

  localparam int SUMW = WIDTH + AVG_LOG2;
  localparam int MW0  = (ANGLE_WIDTH > SUMW) ? ANGLE_WIDTH : SUMW;
  localparam int SW   = ((MW0 > 20) ? MW0 : 20) + 1;
  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic signed [SUMW-1:0] DBL = SUMW'(DB_LO);
  localparam logic signed [SUMW-1:0] DBH = SUMW'(DB_HI);

`ifdef GYRO_TILT_WRAP_EN
  localparam logic signed [SW-1:0] HALF  = SW'(MDEG_HALF_TURN);
  localparam logic signed [SW-1:0] NHALF = -SW'(MDEG_HALF_TURN);
  localparam logic signed [SW-1:0] TURN  = SW'(MDEG_TURN);
`else
  localparam logic signed [SW-1:0] AMAX =
    {{(SW-ANGLE_WIDTH+1){1'b0}}, {(ANGLE_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN = ~AMAX;
`endif

  if (TICK_DIV < CHANNELS + 2) begin : g_bad_div
    $error("TICK_DIV must be at least CHANNELS+2");
  end
  if (ANGLE_WIDTH < 19) begin : g_bad_aw
    $error("ANGLE_WIDTH must be at least 19");
  end
  if (AVG_LOG2 < 1) begin : g_bad_avg
    $error("AVG_LOG2 must be at least 1");
  end

  function automatic logic signed [ANGLE_WIDTH-1:0] step(
    input logic signed [ANGLE_WIDTH-1:0] a,
    input logic signed [SUMW-1:0]        avg
  );
    logic signed [SUMW-1:0] v;
    logic signed [SW-1:0]   s;
    v = ((avg > DBL) && (avg < DBH)) ? '0 : avg;
    s = {{(SW-ANGLE_WIDTH){a[ANGLE_WIDTH-1]}}, a}
      + {{(SW-SUMW){v[SUMW-1]}}, v};
`ifdef GYRO_TILT_WRAP_EN
    if (s >= HALF)      s = s - TURN;
    else if (s < NHALF) s = s + TURN;
`else
    if (s > AMAX)      s = AMAX;
    else if (s < AMIN) s = AMIN;
`endif
    return s[ANGLE_WIDTH-1:0];
  endfunction

  logic [CW-1:0]             cnt_q;
  logic                      tick;
  state_t                    state_q;
  state_t                    state_d;
  logic [CHW-1:0]            ch_q;
  logic                      last_ch;
  logic [AVG_LOG2-1:0]       wptr_q;
  logic [CHANNELS*WIDTH-1:0] snap_q;

  assign tick    = (cnt_q == CW'(TICK_DIV - 1));
  assign last_ch = (ch_q == CHW'(CHANNELS - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             cnt_q <= '0;
    else if (ZERO || tick)  cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = PROC;
      PROC:    if (last_ch) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ZERO) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ch_q   <= '0;
      wptr_q <= '0;
      snap_q <= '0;
    end else if (ZERO) begin
      ch_q   <= '0;
      wptr_q <= '0;
      snap_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (tick) begin
          snap_q <= RATE;
          ch_q   <= '0;
        end
        PROC: ch_q <= last_ch ? '0 : ch_q + 1'b1;
        DONE: wptr_q <= wptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [SUMW-1:0]        avg;
    logic                          push;
    logic signed [ANGLE_WIDTH-1:0] ang_q;

    assign push = (state_q == PROC) && (ch_q == CHW'(c));

    gyro_avg_ring #(
      .WIDTH    (WIDTH),
      .AVG_LOG2 (AVG_LOG2)
    ) u_ring (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .clr    (ZERO),
      .push   (push),
      .wptr   (wptr_q),
      .sample (snap_q[c*WIDTH +: WIDTH]),
      .avg    (avg)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)    ang_q <= '0;
      else if (ZERO) ang_q <= '0;
      else if (push) ang_q <= step(ang_q, avg);
    end

    assign ANGLE[c*ANGLE_WIDTH +: ANGLE_WIDTH] = ang_q;
  end

  assign VALID = (state_q == DONE);
  assign BUSY  = (state_q != IDLE);

endmodule
